// File: rtl/img_frame_proc.sv
// Single-frame buffer and point-operation engine between a UART RX byte stream and a UART TX byte stream.
// Define IMG_FRAME_CHECKSUM_EN to append one XOR checksum byte after every transmitted frame.

module img_frame_proc #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] param,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [1:0]        state_o,
  output logic              frame_done
);

  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] PIX_MAX   = '1;

`ifdef IMG_FRAME_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RECEIVE  = 3'd1,
    S_PROCESS  = 3'd2,
    S_TRANSMIT = 3'd3,
    S_TX_CHK   = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RECEIVE  = 2'd1,
    S_PROCESS  = 2'd2,
    S_TRANSMIT = 2'd3
  } state_e;
`endif

  typedef enum logic [1:0] {
    OP_PASS   = 2'd0,
    OP_INVERT = 2'd1,
    OP_THRESH = 2'd2,
    OP_ADDSAT = 2'd3
  } op_e;

  function automatic logic [DATA_W-1:0] apply_op(input op_e op,
                                                 input logic [DATA_W-1:0] p,
                                                 input logic [DATA_W-1:0] k);
    logic [DATA_W:0] sum;
    sum = {1'b0, p} + {1'b0, k};
    case (op)
      OP_INVERT: apply_op = PIX_MAX - p;
      OP_THRESH: apply_op = (p >= k) ? PIX_MAX : '0;
      OP_ADDSAT: apply_op = sum[DATA_W] ? PIX_MAX : sum[DATA_W-1:0];
      default:   apply_op = p;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                in_ready_q, in_ready_d;
  op_e                 mode_q, mode_d;
  logic [DATA_W-1:0]   param_q, param_d;
  logic                drain_q, drain_d;
  logic                pipe_valid_q, pipe_valid_d;
  logic [ADDR_W-1:0]   pipe_addr_q, pipe_addr_d;
  logic                frame_done_q, frame_done_d;
`ifdef IMG_FRAME_CHECKSUM_EN
  logic [DATA_W-1:0]   chk_q, chk_d;
`endif

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd_data_q;
  logic [ADDR_W-1:0]   rd_addr;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                in_fire;
  logic                out_fire;

  assign in_ready   = in_ready_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);
  assign in_fire    = in_valid & in_ready_q;
  assign out_fire   = out_valid & out_ready;

  // Output side reads straight from the registered memory port, so data holds while stalled.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    state_o   = 2'd0;
    case (state_q)
      S_RECEIVE: state_o = 2'd1;
      S_PROCESS: state_o = 2'd2;
      S_TRANSMIT: begin
        state_o   = 2'd3;
        out_valid = 1'b1;
        out_data  = rd_data_q;
      end
`ifdef IMG_FRAME_CHECKSUM_EN
      S_TX_CHK: begin
        state_o   = 2'd3;
        out_valid = 1'b1;
        out_data  = chk_q;
      end
`endif
      default: state_o = 2'd0;
    endcase
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    mode_d       = mode_q;
    param_d      = param_q;
    drain_d      = drain_q;
    pipe_valid_d = 1'b0;
    pipe_addr_d  = pipe_addr_q;
    frame_done_d = 1'b0;
    rd_addr      = addr_q;
`ifdef IMG_FRAME_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_fire) begin
          mode_d  = op_e'(mode);
          param_d = param;
          addr_d  = ADDR_ONE;
          state_d = S_RECEIVE;
        end
      end
      S_RECEIVE: begin
        if (in_fire) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            state_d = S_PROCESS;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      S_PROCESS: begin
        // Stage 1 reads addr_q; stage 2 writes the result one cycle later, plus one drain cycle.
        if (!drain_q) begin
          pipe_valid_d = 1'b1;
          pipe_addr_d  = addr_q;
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            drain_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end else begin
          drain_d = 1'b0;
          state_d = S_TRANSMIT;
`ifdef IMG_FRAME_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      S_TRANSMIT: begin
        if (out_fire) begin
`ifdef IMG_FRAME_CHECKSUM_EN
          chk_d = chk_q ^ rd_data_q;
`endif
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
`ifdef IMG_FRAME_CHECKSUM_EN
            state_d = S_TX_CHK;
`else
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
`endif
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
        // Prefetch the pixel that will be current next cycle.
        rd_addr = addr_d;
      end
`ifdef IMG_FRAME_CHECKSUM_EN
      S_TX_CHK: begin
        if (out_fire) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE) || (state_d == S_RECEIVE);
  end

  assign wr_en   = rst & (pipe_valid_q | in_fire);
  assign wr_addr = pipe_valid_q ? pipe_addr_q : addr_q;
  assign wr_data = pipe_valid_q ? apply_op(mode_q, rd_data_q, param_q) : in_data;

  // NOTE: the pixel buffer is deliberately not reset; every location is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      in_ready_q   <= 1'b0;
      mode_q       <= OP_PASS;
      param_q      <= '0;
      drain_q      <= 1'b0;
      pipe_valid_q <= 1'b0;
      pipe_addr_q  <= '0;
      frame_done_q <= 1'b0;
`ifdef IMG_FRAME_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      in_ready_q   <= in_ready_d;
      mode_q       <= mode_d;
      param_q      <= param_d;
      drain_q      <= drain_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_addr_q  <= pipe_addr_d;
      frame_done_q <= frame_done_d;
`ifdef IMG_FRAME_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

endmodule

// File: tb/tb_img_frame_proc.sv
// Scoreboard bench for img_frame_proc: a 16-pixel instance for the main scenarios, a 4-pixel one for the short frame.
// Expected pixels (and the checksum byte when IMG_FRAME_CHECKSUM_EN is defined) are queued at send time.

module tb_img_frame_proc;

  localparam int BIG   = 16;
  localparam int SMALL = 4;
`ifdef IMG_FRAME_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] param = 8'h00;
  logic       out_ready = 1'b0;

  logic       b_in_ready, b_out_valid, b_busy, b_frame_done;
  logic [7:0] b_out_data;
  logic [1:0] b_state;
  logic       s_in_ready, s_out_valid, s_busy, s_frame_done;
  logic [7:0] s_out_data;
  logic [1:0] s_state;

  bit         sel_small = 1'b0;
  logic       cur_in_ready, cur_out_valid, cur_busy, cur_frame_done;
  logic [7:0] cur_out_data;
  logic [1:0] cur_state_o;

  assign cur_in_ready   = sel_small ? s_in_ready   : b_in_ready;
  assign cur_out_valid  = sel_small ? s_out_valid  : b_out_valid;
  assign cur_out_data   = sel_small ? s_out_data   : b_out_data;
  assign cur_busy       = sel_small ? s_busy       : b_busy;
  assign cur_frame_done = sel_small ? s_frame_done : b_frame_done;
  assign cur_state_o    = sel_small ? s_state      : b_state;

  always #5 clk = ~clk;

  img_frame_proc #(.DATA_W(8), .DEPTH(BIG)) u_big (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_in_ready),
    .mode(mode), .param(param), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(out_ready), .busy(b_busy), .state_o(b_state), .frame_done(b_frame_done)
  );

  img_frame_proc #(.DATA_W(8), .DEPTH(SMALL)) u_small (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .mode(mode), .param(param), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .busy(s_busy), .state_o(s_state), .frame_done(s_frame_done)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pix[BIG];
  logic [7:0] chk_acc;

  function automatic logic [7:0] model_op(input logic [1:0] m, input logic [7:0] k, input logic [7:0] p);
    int s;
    case (m)
      2'd0: return p;
      2'd1: return 8'hFF - p;
      2'd2: return (p < k) ? 8'h00 : 8'hFF;
      default: begin
        s = int'(p) + int'(k);
        return (s > 255) ? 8'hFF : 8'(s);
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input logic [1:0] m, input logic [7:0] k, input int n,
                            input bit gaps, input bit scramble);
    bit         acc;
    int         wait_cyc;
    logic [7:0] exp_v;
    mode    = m;
    param   = k;
    chk_acc = 8'h00;
    for (int i = 0; i < n; i++) begin
      in_data  = pix[i];
      in_valid = 1'b1;
      wait_cyc = 0;
      do begin
        acc = cur_in_ready;
        tick();
        wait_cyc++;
      end while (!acc && wait_cyc < 50);
      in_valid = 1'b0;
      n_cmp++;
      if (acc !== 1'b1) begin
        n_err++;
        $display("FAIL send_accept byte %0d: in_ready got %0b want 1", i, acc);
      end else begin
        exp_v = model_op(m, k, pix[i]);
        exp_q.push_back(exp_v);
        chk_acc ^= exp_v;
      end
      if (scramble) begin
        mode  = 2'($urandom_range(0, 3));
        param = 8'($urandom);
      end
      if (gaps && i < n - 1) repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic wait_process(input int n, input bit junk);
    int cnt = 0;
    n_cmp++;
    if (cur_state_o !== 2'd2 || cur_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL process_entry: state_o=%0d in_ready=%0b want 2 and 0", cur_state_o, cur_in_ready);
    end
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'hA5;
    end
    while (cur_state_o === 2'd2 && cnt < 4 * n) begin
      cnt++;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (cnt !== n + 1) begin
      n_err++;
      $display("FAIL process_cycles: got %0d want %0d", cnt, n + 1);
    end
    n_cmp++;
    if (cur_state_o !== 2'd3) begin
      n_err++;
      $display("FAIL tx_entry: state_o got %0d want 3", cur_state_o);
    end
`ifdef IMG_FRAME_CHECKSUM_EN
    exp_q.push_back(chk_acc);
`endif
  endtask

  task automatic collect(input int n_out, input bit rand_ready);
    int         got = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_v;
    while (got < n_out && cyc < 50 * n_out + 50) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        n_cmp++;
        if (cur_out_valid !== 1'b1 || cur_out_data !== held) begin
          n_err++;
          $display("FAIL stall_hold: valid=%0b data=%02h want 1 and %02h", cur_out_valid, cur_out_data, held);
        end
      end
      n_cmp++;
      if (cur_frame_done !== 1'b0) begin
        n_err++;
        $display("FAIL early_frame_done at output %0d: got %0b want 0", got, cur_frame_done);
      end
      if (cur_out_valid === 1'b1 && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %02h want none", cur_out_data);
        end else begin
          exp_v = exp_q.pop_front();
          if (cur_out_data !== exp_v) begin
            n_err++;
            $display("FAIL out_data[%0d]: got %02h want %02h", got, cur_out_data, exp_v);
          end
        end
        got++;
        stalled = 1'b0;
      end else begin
        stalled = (cur_out_valid === 1'b1);
        held    = cur_out_data;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    n_cmp++;
    if (got !== n_out) begin
      n_err++;
      $display("FAIL tx_count: got %0d want %0d", got, n_out);
    end
    n_cmp++;
    if (cur_frame_done !== 1'b1) begin
      n_err++;
      $display("FAIL frame_done_pulse: got %0b want 1", cur_frame_done);
    end
    n_cmp++;
    if (cur_state_o !== 2'd0 || cur_busy !== 1'b0 || cur_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_return: state_o=%0d busy=%0b out_valid=%0b want 0 0 0", cur_state_o, cur_busy, cur_out_valid);
    end
    tick();
    n_cmp++;
    if (cur_frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL frame_done_width: got %0b want 0", cur_frame_done);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (cur_state_o !== 2'd0 || cur_busy !== 1'b0 || cur_in_ready !== 1'b0 ||
        cur_out_valid !== 1'b0 || cur_out_data !== 8'h00 || cur_frame_done !== 1'b0) begin
      n_err++;
      $display("FAIL %s: state_o=%0d busy=%0b in_ready=%0b out_valid=%0b out_data=%02h frame_done=%0b want all 0",
               tag, cur_state_o, cur_busy, cur_in_ready, cur_out_valid, cur_out_data, cur_frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset_state");
    rst = 1'b1;
    tick();
    n_cmp++;
    if (cur_in_ready !== 1'b1 || cur_state_o !== 2'd0) begin
      n_err++;
      $display("FAIL idle_ready: in_ready=%0b state_o=%0d want 1 and 0", cur_in_ready, cur_state_o);
    end
  endtask

  task automatic test_invert();
    for (int i = 0; i < BIG; i++) pix[i] = 8'(i);
    send_bytes(2'd1, 8'h00, BIG, 1'b0, 1'b0);
    wait_process(BIG, 1'b0);
    collect(BIG + CHK_EXTRA, 1'b0);
  endtask

  task automatic test_threshold();
    for (int i = 0; i < BIG; i++) pix[i] = 8'(i);
    send_bytes(2'd2, 8'h08, BIG, 1'b0, 1'b0);
    wait_process(BIG, 1'b0);
    collect(BIG + CHK_EXTRA, 1'b0);
  endtask

  task automatic test_addsat();
    pix[0] = 8'h00;
    pix[1] = 8'h05;
    pix[2] = 8'h06;
    pix[3] = 8'hFF;
    for (int i = 4; i < BIG; i++) pix[i] = 8'($urandom);
    send_bytes(2'd3, 8'hFA, BIG, 1'b0, 1'b0);
    wait_process(BIG, 1'b0);
    collect(BIG + CHK_EXTRA, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < BIG; i++) pix[i] = 8'($urandom);
    send_bytes(2'd3, 8'h40, BIG, 1'b1, 1'b1);
    wait_process(BIG, 1'b1);
    collect(BIG + CHK_EXTRA, 1'b1);
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < BIG; i++) pix[i] = 8'($urandom);
    send_bytes(2'd0, 8'h00, 7, 1'b0, 1'b0);
    n_cmp++;
    if (cur_state_o !== 2'd1) begin
      n_err++;
      $display("FAIL partial_receive: state_o got %0d want 1", cur_state_o);
    end
    exp_q.delete();
    rst = 1'b0;
    tick();
    check_reset_outputs("reset_midframe");
    rst = 1'b1;
    tick();
    for (int i = 0; i < BIG; i++) pix[i] = 8'(8'h30 + 3 * i);
    send_bytes(2'd1, 8'h00, BIG, 1'b0, 1'b0);
    wait_process(BIG, 1'b0);
    collect(BIG + CHK_EXTRA, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < BIG; i++) pix[i] = 8'($urandom);
    send_bytes(2'd0, 8'h00, BIG, 1'b0, 1'b0);
    wait_process(BIG, 1'b0);
    collect(BIG + CHK_EXTRA, 1'b0);
    for (int i = 0; i < BIG; i++) pix[i] = 8'($urandom);
    send_bytes(2'd2, 8'h80, BIG, 1'b0, 1'b0);
    wait_process(BIG, 1'b0);
    collect(BIG + CHK_EXTRA, 1'b0);
  endtask

  task automatic test_small_frame();
    sel_small = 1'b1;
    in_valid  = 1'b0;
    rst = 1'b0;
    tick();
    check_reset_outputs("small_reset");
    rst = 1'b1;
    tick();
    pix[0] = 8'h01;
    pix[1] = 8'h02;
    pix[2] = 8'h04;
    pix[3] = 8'h08;
    send_bytes(2'd0, 8'h00, SMALL, 1'b0, 1'b0);
    wait_process(SMALL, 1'b0);
    collect(SMALL + CHK_EXTRA, 1'b0);
  endtask

  initial begin
    test_reset();
    test_invert();
    test_threshold();
    test_addsat();
    test_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_small_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "time limit exceeded");
  end

endmodule
